// File: rtl/stu_multi_fork_controller.sv
// Fork controller: L1 block dispatch across idle cores and predictor-gated L2 loop forks,
// with per-core task FSMs and a saturating history predictor table (HPT) trained on retirement.
module stu_multi_fork_controller #(
  parameter int NUM_CORES    = 4,
  parameter int BLOCK_SIZE   = 4,
  parameter int L1_SPLIT     = 2,
  parameter int MAX_L2_TASKS = 2,
  parameter int HPT_DEPTH    = 64,
  parameter int HPT_CTR_BITS = 2
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [31:0]                                    pc_in,
  input  logic [BLOCK_SIZE*32-1:0]                       block_in,
  input  logic                                           block_valid_in,
  input  logic [1:0]                                     spec_level_in,
  input  logic [NUM_CORES-1:0]                           core_busy_in,
  input  logic [NUM_CORES-1:0]                           squash_in,
  input  logic [NUM_CORES-1:0]                           commit_in,
  input  logic [NUM_CORES-1:0]                           ctx_copy_done_in,
  output logic [NUM_CORES-1:0]                           l1_dispatch_valid_out,
  output logic [NUM_CORES*(BLOCK_SIZE/L1_SPLIT)*32-1:0]  l1_dispatch_data_out,
  output logic [NUM_CORES-1:0]                           ctx_copy_start_out,
  output logic [NUM_CORES-1:0]                           spec_start_out,
  output logic [NUM_CORES-1:0]                           task_active_out,
  output logic [NUM_CORES*32-1:0]                        spec_pc_out,
  output logic                                           hpt_update_pending_out
);
  // state  | meaning
  // FREE   | core idle, may take an L1 dispatch or an L2 fork
  // COPY   | context copy in flight for a forked task
  // ACTIVE | speculative task running
  // RETIRE | task finished, waiting for its HPT update slot
  localparam int SLOTS = BLOCK_SIZE / L1_SPLIT;
  localparam int CW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int IW    = $clog2(HPT_DEPTH);
  localparam logic [HPT_CTR_BITS-1:0] CTR_INIT = HPT_CTR_BITS'(1 << (HPT_CTR_BITS-1));
  localparam logic [HPT_CTR_BITS-1:0] CTR_MAX  = '1;

  typedef enum logic [1:0] {FREE, COPY, ACTIVE, RETIRE} core_state_t;

  core_state_t             state_q [NUM_CORES];
  core_state_t             state_d [NUM_CORES];
  logic [31:0]             spc_q   [NUM_CORES];
  logic [31:0]             tpc_q   [NUM_CORES];
  logic [NUM_CORES-1:0]    inc_q, inc_d;
  logic [HPT_CTR_BITS-1:0] hpt_q   [HPT_DEPTH];

  logic [31:0] last_inst, imm, target;
  logic        trigger;

  assign last_inst = block_in[(BLOCK_SIZE-1)*32 +: 32];
  assign imm       = {{20{last_inst[31]}}, last_inst[7], last_inst[30:25], last_inst[11:8], 1'b0};
  assign target    = pc_in + 32'(4*(BLOCK_SIZE-1)) + imm;
  assign trigger   = block_valid_in && (last_inst[6:0] == 7'b1100011) && (target < pc_in);

  logic [NUM_CORES-1:0] eligible;
  int                   n_elig, n_live;
  logic                 dup;

  always_comb begin
    eligible = '0;
    n_elig   = 0;
    n_live   = 0;
    dup      = 1'b0;
    for (int i = 1; i < NUM_CORES; i++) begin
      if (state_q[i] == FREE && !core_busy_in[i]) begin
        eligible[i] = 1'b1;
        n_elig++;
      end
      if (state_q[i] == COPY || state_q[i] == ACTIVE) begin
        n_live++;
        if (tpc_q[i] == pc_in) dup = 1'b1;
      end
    end
  end

  // rank = position of the core among selected eligible cores; selects the interleaved words
  int rank;
  always_comb begin
    l1_dispatch_valid_out = '0;
    l1_dispatch_data_out  = '0;
    rank                  = 0;
    if (rst && spec_level_in == 2'd1 && block_valid_in && n_elig >= L1_SPLIT) begin
      for (int i = 1; i < NUM_CORES; i++) begin
        if (eligible[i] && rank < L1_SPLIT) begin
          l1_dispatch_valid_out[i] = 1'b1;
          for (int r = 0; r < L1_SPLIT; r++) begin
            if (rank == r) begin
              for (int j = 0; j < SLOTS; j++)
                l1_dispatch_data_out[(i*SLOTS+j)*32 +: 32] = block_in[(r+j*L1_SPLIT)*32 +: 32];
            end
          end
          rank++;
        end
      end
    end
  end

  logic [IW-1:0] hpt_idx;
  logic          predict, fork_found, fork_en;
  logic [CW-1:0] fork_core;

  assign hpt_idx = pc_in[IW+1:2];
  assign predict = hpt_q[hpt_idx][HPT_CTR_BITS-1];

  always_comb begin
    fork_core  = '0;
    fork_found = 1'b0;
    for (int i = 1; i < NUM_CORES; i++) begin
      if (eligible[i] && !fork_found) begin
        fork_core  = CW'(i);
        fork_found = 1'b1;
      end
    end
    fork_en = rst && spec_level_in == 2'd2 && trigger && fork_found &&
              (n_live < MAX_L2_TASKS) && predict && !dup;
  end

  logic                    svc_valid, svc_inc;
  logic [CW-1:0]           svc_core;
  logic [IW-1:0]           svc_idx;
  logic [HPT_CTR_BITS-1:0] svc_ctr, hpt_next;

  always_comb begin
    svc_valid = 1'b0;
    svc_core  = '0;
    svc_idx   = '0;
    svc_inc   = 1'b0;
    for (int i = 1; i < NUM_CORES; i++) begin
      if (state_q[i] == RETIRE && !svc_valid) begin
        svc_valid = 1'b1;
        svc_core  = CW'(i);
        svc_idx   = tpc_q[i][IW+1:2];
        svc_inc   = inc_q[i];
      end
    end
    svc_ctr = hpt_q[svc_idx];
    if (svc_inc) hpt_next = (svc_ctr == CTR_MAX) ? svc_ctr : svc_ctr + 1'b1;
    else         hpt_next = (svc_ctr == '0)      ? svc_ctr : svc_ctr - 1'b1;
  end

  always_comb begin
    inc_d              = inc_q;
    ctx_copy_start_out = '0;
    spec_start_out     = '0;
    for (int i = 0; i < NUM_CORES; i++) state_d[i] = state_q[i];
    for (int i = 1; i < NUM_CORES; i++) begin
      case (state_q[i])
        FREE: if (fork_en && fork_core == CW'(i)) begin
          state_d[i]            = COPY;
          ctx_copy_start_out[i] = 1'b1;
        end
        COPY: if (squash_in[i]) begin
          state_d[i] = RETIRE;
          inc_d[i]   = 1'b0;
        end else if (ctx_copy_done_in[i]) begin
          state_d[i]        = ACTIVE;
          spec_start_out[i] = 1'b1;
        end
        ACTIVE: if (squash_in[i]) begin
          state_d[i] = RETIRE;
          inc_d[i]   = 1'b0;
        end else if (commit_in[i]) begin
          state_d[i] = RETIRE;
          inc_d[i]   = 1'b1;
        end
        RETIRE: if (svc_valid && svc_core == CW'(i)) state_d[i] = FREE;
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_comb begin
    task_active_out = '0;
    spec_pc_out     = '0;
    for (int i = 1; i < NUM_CORES; i++) begin
      task_active_out[i]     = (state_q[i] == COPY) || (state_q[i] == ACTIVE);
      spec_pc_out[i*32 +: 32] = spc_q[i];
    end
  end

  assign hpt_update_pending_out = svc_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= FREE;
        spc_q[i]   <= '0;
        tpc_q[i]   <= '0;
      end
      inc_q <= '0;
      for (int k = 0; k < HPT_DEPTH; k++) hpt_q[k] <= CTR_INIT;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= state_d[i];
        if (fork_en && fork_core == CW'(i)) begin
          spc_q[i] <= target;
          tpc_q[i] <= pc_in;
        end
      end
      inc_q <= inc_d;
      if (svc_valid) hpt_q[svc_idx] <= hpt_next;
    end
  end
endmodule

// File: tb/tb_stu_multi_fork_controller.sv
// Bench for stu_multi_fork_controller: directed scenarios plus random traffic, all cycles
// checked against a task-level reference model of cores, forks and predictor counters.
module tb_stu_multi_fork_controller;
  localparam int NC = 4, BS = 4, SP = 2, SL = BS / SP;
  localparam int MF = 0, MC = 1, MA = 2, MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [31:0]          pc;
  logic [BS*32-1:0]     blk;
  logic                 bv;
  logic [1:0]           lvl;
  logic [NC-1:0]        busy, sq, cm, dn;
  logic [NC-1:0]        l1_val, cs, ss, ta;
  logic [NC*SL*32-1:0]  l1_data;
  logic [NC*32-1:0]     spc;
  logic                 pend;

  int errors = 0, checks = 0;

  int          m_st  [NC];
  logic [31:0] m_spc [NC];
  logic [31:0] m_tpc [NC];
  bit          m_up  [NC];
  int          m_hpt [64];

  stu_multi_fork_controller dut (
    .clk(clk), .rst(rst), .pc_in(pc), .block_in(blk), .block_valid_in(bv),
    .spec_level_in(lvl), .core_busy_in(busy), .squash_in(sq), .commit_in(cm),
    .ctx_copy_done_in(dn), .l1_dispatch_valid_out(l1_val), .l1_dispatch_data_out(l1_data),
    .ctx_copy_start_out(cs), .spec_start_out(ss), .task_active_out(ta),
    .spec_pc_out(spc), .hpt_update_pending_out(pend)
  );

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_st[c] = MF; m_spc[c] = 0; m_tpc[c] = 0; m_up[c] = 0;
    end
    for (int k = 0; k < 64; k++) m_hpt[k] = 2;
  endtask

  task automatic idle();
    pc = 0; blk = '0; bv = 0; lvl = 0; busy = 0; sq = 0; cm = 0; dn = 0;
  endtask

  task automatic trig_at(input logic [31:0] p);
    idle();
    pc  = p;
    blk = {32'hFE0008E3, 32'($urandom()), 32'($urandom()), 32'($urandom())};
    bv  = 1; lvl = 2;
  endtask

  // One clock: compare every output with the model, then advance the model at the edge.
  task automatic step();
    logic [31:0] inst, tgt, imm;
    bit trig, dup, fk;
    int live, fc, idx, svc, q[$];
    logic [NC-1:0] e_val, e_cs, e_ss, e_ta;
    logic [NC*SL*32-1:0] e_data;
    logic [NC*32-1:0] e_spc;
    logic e_pend;
    if (!rst) model_reset();
    inst = blk[BS*32-1 -: 32];
    imm  = 32'(int'(inst[7])*2048 + int'(inst[30:25])*32 + int'(inst[11:8])*2)
           - (inst[31] ? 32'd4096 : 32'd0);
    tgt  = pc + 32'(4*(BS-1)) + imm;
    trig = bv && inst[6:0] == 7'h63 && tgt < pc;
    live = 0; dup = 0;
    for (int c = 1; c < NC; c++) begin
      if (m_st[c] == MF && !busy[c]) q.push_back(c);
      if (m_st[c] == MC || m_st[c] == MA) begin
        live++;
        if (m_tpc[c] == pc) dup = 1;
      end
    end
    e_val = 0; e_data = 0; e_cs = 0; e_ss = 0; e_ta = 0; e_spc = 0;
    if (rst && lvl == 1 && bv && q.size() >= SP)
      for (int r = 0; r < SP; r++) begin
        e_val[q[r]] = 1;
        for (int j = 0; j < SL; j++) e_data[(q[r]*SL+j)*32 +: 32] = blk[(r+j*SP)*32 +: 32];
      end
    idx = int'(pc[7:2]);
    fk  = rst && lvl == 2 && trig && q.size() > 0 && live < 2 && m_hpt[idx] >= 2 && !dup;
    fc  = fk ? q[0] : 0;
    if (fk) e_cs[fc] = 1;
    svc = 0;
    for (int c = NC-1; c >= 1; c--) if (m_st[c] == MR) svc = c;
    e_pend = (svc != 0);
    for (int c = 1; c < NC; c++) begin
      e_ta[c] = (m_st[c] == MC || m_st[c] == MA);
      e_ss[c] = (m_st[c] == MC && dn[c] && !sq[c]);
      e_spc[c*32 +: 32] = m_spc[c];
    end
    #1;
    checks++; if (l1_val !== e_val) begin errors++; $display("FAIL l1_valid got=%h exp=%h t=%0t", l1_val, e_val, $time); end
    checks++; if (l1_data !== e_data) begin errors++; $display("FAIL l1_data got=%h exp=%h t=%0t", l1_data, e_data, $time); end
    checks++; if (cs !== e_cs) begin errors++; $display("FAIL ctx_copy_start got=%h exp=%h t=%0t", cs, e_cs, $time); end
    checks++; if (ss !== e_ss) begin errors++; $display("FAIL spec_start got=%h exp=%h t=%0t", ss, e_ss, $time); end
    checks++; if (ta !== e_ta) begin errors++; $display("FAIL task_active got=%h exp=%h t=%0t", ta, e_ta, $time); end
    checks++; if (spc !== e_spc) begin errors++; $display("FAIL spec_pc got=%h exp=%h t=%0t", spc, e_spc, $time); end
    checks++; if (pend !== e_pend) begin errors++; $display("FAIL hpt_pending got=%b exp=%b t=%0t", pend, e_pend, $time); end
    @(posedge clk);
    if (rst) begin
      for (int c = 1; c < NC; c++) begin
        if (m_st[c] == MC) begin
          if (sq[c]) begin m_st[c] = MR; m_up[c] = 0; end
          else if (dn[c]) m_st[c] = MA;
        end else if (m_st[c] == MA) begin
          if (sq[c]) begin m_st[c] = MR; m_up[c] = 0; end
          else if (cm[c]) begin m_st[c] = MR; m_up[c] = 1; end
        end
      end
      if (svc != 0) begin
        idx = int'(m_tpc[svc][7:2]);
        if (m_up[svc]) m_hpt[idx] = (m_hpt[idx] < 3) ? m_hpt[idx] + 1 : 3;
        else           m_hpt[idx] = (m_hpt[idx] > 0) ? m_hpt[idx] - 1 : 0;
        m_st[svc] = MF;
      end
      if (fk) begin m_st[fc] = MC; m_spc[fc] = tgt; m_tpc[fc] = pc; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 0; idle(); step();
    rst = 1; step();
  endtask

  task automatic test_reset();
    rst = 0;
    for (int n = 0; n < 3; n++) begin
      trig_at(32'h1000); busy = 4'($urandom()); dn = 4'($urandom()); cm = 4'($urandom());
      #1;
      checks++;
      if ({l1_val, cs, ss, ta, spc, pend} !== '0 || l1_data !== '0) begin
        errors++; $display("FAIL reset_outputs got=%h exp=0", {l1_val, cs, ss, ta, pend});
      end
      step();
    end
    rst = 1; idle(); step();
  endtask

  task automatic test_fork_basic();
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL fork_start got=%b exp=0010", cs); end
    step();
    idle(); dn = 4'b0010; #1;
    checks++; if (ss !== 4'b0010) begin errors++; $display("FAIL fork_spec_start got=%b exp=0010", ss); end
    checks++; if (spc[63:32] !== 32'h00000FFC) begin errors++; $display("FAIL fork_spec_pc got=%h exp=00000ffc", spc[63:32]); end
    step();
  endtask

  task automatic test_limits();
    trig_at(32'h3004); #1;
    checks++; if (cs !== 4'b0100) begin errors++; $display("FAIL second_fork got=%b exp=0100", cs); end
    step();
    trig_at(32'h2000); #1;
    checks++; if (cs !== 4'b0000) begin errors++; $display("FAIL max_tasks got=%b exp=0000", cs); end
    step();
    idle(); sq = 4'b0100; step();
    idle(); step();
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0000) begin errors++; $display("FAIL duplicate got=%b exp=0000", cs); end
    step();
    idle(); cm = 4'b0010; step();
    idle(); step(); step();
  endtask

  task automatic test_l1_dispatch();
    idle(); lvl = 1; bv = 1; busy = 4'b0010;
    blk = {32'hD, 32'hC, 32'hB, 32'hA}; #1;
    checks++; if (l1_val !== 4'b1100) begin errors++; $display("FAIL l1_cores got=%b exp=1100", l1_val); end
    checks++;
    if (l1_data[4*32 +: 64] !== {32'hC, 32'hA} || l1_data[6*32 +: 64] !== {32'hD, 32'hB}) begin
      errors++; $display("FAIL l1_slots got=%h exp=0000000d0000000b0000000c0000000a", l1_data[4*32 +: 128]);
    end
    step();
    busy = 4'b0110; #1;
    checks++; if (l1_val !== 4'b0000) begin errors++; $display("FAIL l1_short got=%b exp=0000", l1_val); end
    step();
  endtask

  task automatic test_hpt_order();
    do_reset();
    trig_at(32'h1000); step();
    idle(); dn = 4'b0010; step();
    trig_at(32'h1004); step();
    idle(); dn = 4'b0100; step();
    idle(); sq = 4'b0010; cm = 4'b0100; step();
    idle();
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (pend !== (n < 2)) begin errors++; $display("FAIL pending_cycle%0d got=%b exp=%b", n, pend, n < 2); end
      step();
    end
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0000) begin errors++; $display("FAIL hpt_dec got=%b exp=0000", cs); end
    step();
    trig_at(32'h1004); #1;
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL hpt_inc got=%b exp=0010", cs); end
    step();
    idle(); sq = 4'b0010; step();
    idle(); step();
  endtask

  task automatic test_saturation();
    do_reset();
    trig_at(32'h1000); step();
    trig_at(32'h1100); step();
    idle(); sq = 4'b0110; step();
    idle(); step(); step();
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0000) begin errors++; $display("FAIL sat_low got=%b exp=0000", cs); end
    step();
    do_reset();
    trig_at(32'h1000); step();
    idle(); dn = 4'b0010; step();
    trig_at(32'h1100); step();
    idle(); dn = 4'b0100; step();
    idle(); cm = 4'b0110; step();
    idle(); step(); step();
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL sat_high got=%b exp=0010", cs); end
    step();
    idle(); sq = 4'b0010; step();
    idle(); step();
    trig_at(32'h1100); #1;
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL sat_after_dec got=%b exp=0010", cs); end
    step();
    idle(); sq = 4'b0010; step();
    idle(); step();
  endtask

  task automatic test_squash_copy_reset();
    do_reset();
    trig_at(32'h1000); step();
    idle(); sq = 4'b0010; dn = 4'b0010; #1;
    checks++; if (ss !== 4'b0000) begin errors++; $display("FAIL squash_copy_start got=%b exp=0000", ss); end
    step();
    idle(); #1;
    checks++; if (ta !== 4'b0000) begin errors++; $display("FAIL squash_copy_active got=%b exp=0000", ta); end
    step(); step();
    trig_at(32'h1008); step();
    idle(); dn = 4'b0010; step();
    rst = 0; #1;
    checks++;
    if ({l1_val, cs, ss, ta, spc, pend} !== '0) begin errors++; $display("FAIL mid_reset got=%h exp=0", {cs, ss, ta, pend}); end
    step();
    rst = 1; idle(); dn = 4'b0010; cm = 4'b0010; step();
    trig_at(32'h1000); #1;
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL hpt_reinit got=%b exp=0010", cs); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] pool [5];
    pool = '{32'h1000, 32'h1004, 32'h1100, 32'h2000, 32'h3008};
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) != 0);
      pc  = pool[$urandom_range(0, 4)];
      case ($urandom_range(0, 3))
        0, 1:    blk = {32'hFE0008E3, 32'($urandom()), 32'($urandom()), 32'($urandom())};
        2:       blk = {32'h00000863, 32'($urandom()), 32'($urandom()), 32'($urandom())};
        default: blk = {32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
      endcase
      bv   = ($urandom_range(0, 4) != 0);
      lvl  = 2'($urandom_range(0, 3));
      busy = 4'($urandom()) & 4'($urandom());
      for (int c = 0; c < NC; c++) begin
        sq[c] = ($urandom_range(0, 9) == 0);
        cm[c] = ($urandom_range(0, 6) == 0);
        dn[c] = ($urandom_range(0, 2) == 0);
      end
      step();
    end
    rst = 1;
  endtask

  initial begin
    rst = 0; idle(); model_reset();
    @(negedge clk);
    test_reset();
    test_fork_basic();
    test_limits();
    test_l1_dispatch();
    test_hpt_order();
    test_saturation();
    test_squash_copy_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stu_multi_fork_controller.md
STU_MULTI_FORK_CONTROLLER -- requirements
Module: stu_multi_fork_controller

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, total cores; core 0 is master and is never allocated.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, instructions per fetch block.
REQ-003 SHALL have parameter L1_SPLIT, default 2, cores per L1 dispatch; BLOCK_SIZE % L1_SPLIT == 0 and L1_SPLIT <= NUM_CORES-1.
REQ-004 SHALL have parameter MAX_L2_TASKS, default 2, maximum concurrent L2 tasks, 1..NUM_CORES-1.
REQ-005 SHALL have parameters HPT_DEPTH, default 64, and HPT_CTR_BITS, default 2, giving predictor entries and counter width.
REQ-006 SHALL have port clk, in, 1, the single clock.
REQ-007 SHALL have port rst, in, 1, reset; asynchronous, active-low.
REQ-008 SHALL have ports pc_in, in, 32, block PC; block_in, in, BLOCK_SIZE x 32, instructions; block_valid_in, in, 1.
REQ-009 SHALL have ports spec_level_in, in, spec_level_t, with values 0 bypass, 1 conservative, 2 optimistic; core_busy_in, in, NUM_CORES.
REQ-010 SHALL have ports squash_in, commit_in and ctx_copy_done_in, each in, NUM_CORES, per-core feedback.
REQ-011 SHALL have ports l1_dispatch_valid_out, out, NUM_CORES; l1_dispatch_data_out, out, NUM_CORES x (BLOCK_SIZE/L1_SPLIT) x 32.
REQ-012 SHALL have ports ctx_copy_start_out, spec_start_out and task_active_out, each out, NUM_CORES; spec_pc_out, out, NUM_CORES x 32.
REQ-013 SHALL have port hpt_update_pending_out, out, 1, which is high while any HPT update is queued.

Function
REQ-014 SHALL decode the loop trigger from block_in[BLOCK_SIZE-1]:
- opcode 1100011
- B-type immediate, sign-extended
- target = pc_in + 4*(BLOCK_SIZE-1) + imm, mod 2^32
- trigger = block_valid_in AND backward, where backward means target < pc_in, unsigned.
REQ-015 SHALL keep one FSM per core 1..NUM_CORES-1 with states FREE, COPY, ACTIVE, RETIRE.
REQ-016 SHALL treat a core as eligible only if it is FREE and its core_busy_in bit is 0.
REQ-017 In level 1 with block_valid_in, if at least L1_SPLIT cores are eligible, SHALL combinationally select the L1_SPLIT lowest-index eligible cores.
- Selected core k receives block_in[k + j*L1_SPLIT] in slot j.
- l1_dispatch_valid_out is asserted for those cores in the same cycle.
- Otherwise nothing is dispatched.
- Core FSMs do not change.
REQ-018 In level 2, a fork SHALL occur when all of the following hold:
- trigger is true
- an eligible core exists
- fewer than MAX_L2_TASKS cores are in COPY or ACTIVE
- HPT counter MSB at index pc_in[log2(HPT_DEPTH)+1:2] is 1
- no live task holds the same trigger PC.
REQ-019 On a fork, the lowest-index eligible core SHALL take these actions:
- pulse its ctx_copy_start_out for 1 cycle, combinationally
- move to COPY at the next edge
- latch spec_pc_out with the target and an internal trigger PC with pc_in.
REQ-020 In COPY, squash SHALL move the core to RETIRE with a decrement queued; otherwise ctx_copy_done_in pulses spec_start_out for 1 cycle and moves the core to ACTIVE; commit_in is ignored.
REQ-021 In ACTIVE, squash SHALL move the core to RETIRE with a decrement queued; otherwise commit moves it to RETIRE with an increment queued; squash wins over a simultaneous commit.
REQ-022 task_active_out[i] SHALL be 1 in COPY and ACTIVE only.
REQ-023 SHALL perform at most one HPT update per cycle.
- The lowest-index core in RETIRE is serviced.
- The update uses that core's latched trigger PC, not pc_in.
- The counter saturates at 0 and 2^HPT_CTR_BITS-1.
- The serviced core returns to FREE at the next edge.
REQ-024 An HPT lookup SHALL see the pre-update value when an update to the same index occurs in the same cycle.
REQ-025 Levels 0 and 3 SHALL produce no dispatch and no fork; cores already in COPY or ACTIVE continue to resolve normally.
REQ-026 Core 0 outputs SHALL be held at 0.

Reset
REQ-027 While rst=0, all cores SHALL be FREE, every spec_pc_out and trigger register 0, every HPT counter 2^(HPT_CTR_BITS-1) (weakly predict success), and all outputs 0.
REQ-028 Reset asserted mid-operation SHALL abort all tasks and discard queued updates, with no pulses after release until new stimulus.

Verification
REQ-029 Reset, then pc_in=0x1000, block_in[3]=0xFE0008E3, level 2, no core busy, then ctx_copy_done_in[1] -> ctx_copy_start_out[1] pulses with spec_pc_out[1]=0x00000FFC, and spec_start_out[1] pulses the following cycle.
REQ-030 Level 1, block_in={0xA,0xB,0xC,0xD}, core_busy_in=4'b0010 -> cores 2,3 valid; core2 receives {0xA,0xC} and core3 receives {0xB,0xD}.
REQ-031 With 2 tasks live, a third trigger at pc_in=0x2000 -> no fork; a repeat trigger at pc_in=0x1000 with a free core -> no fork (duplicate suppression).
REQ-032 Squash[1] and commit[2] in the same cycle -> core1 updated first (counter 2->1), core2 the next cycle (2->3); hpt_update_pending_out high for 2 cycles.
REQ-033 Two squashes at 0x1000 -> counter 0; next trigger at 0x1000 -> no fork; two commits -> counter saturates at 3.
REQ-034 Squash in COPY -> spec_start_out never pulses; task_active_out drops the next cycle; rst pulsed while ACTIVE -> all outputs 0 and HPT reinitialised to 2.
